// File: rtl/instr_stream_feeder.sv
// Instruction store plus valid/ready streamer that feeds a CPU instruction port.
// Define FEEDER_STALL_CNT_EN to add the stall_cnt output (consumer back-pressure cycles).
module instr_stream_feeder #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 17,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  input  logic              loop_mode,
  input  logic              abort,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_idx,
  output logic              busy,
  output logic              done,
`ifdef FEEDER_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [7:0]        loop_cnt
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic                loop_q, loop_d;
  logic [7:0]          loop_cnt_q, loop_cnt_d;
  logic                start_acc;
  logic                wr_en;
  logic                last_word;
  logic [DATA_W-1:0]   rd_word;

  // Loads land only while idle, so the store is frozen for the whole run.
  assign wr_en = (state_q == IDLE) && load_en && !abort && ({1'b0, load_addr} < DEPTH_C);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[load_addr] <= load_data;
  end

  assign last_word = ({1'b0, idx_q} == (n_q - 1'b1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    n_d        = n_q;
    loop_d     = loop_q;
    loop_cnt_d = loop_cnt_q;
    start_acc  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            start_acc  = 1'b1;
            n_d        = (count > DEPTH_C) ? DEPTH_C : count;
            loop_d     = loop_mode;
            loop_cnt_d = '0;
            idx_d      = '0;
            if (n_d == '0) begin
              state_d = DONE;
            end else begin
              state_d = RUN;
              valid_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (valid_q && instr_ready) begin
            if (last_word) begin
              idx_d = '0;
              if (loop_q) begin
                loop_cnt_d = loop_cnt_q + 8'd1;
              end else begin
                state_d = DONE;
                valid_d = 1'b0;
              end
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Bypass lets a load issued with start reach the very first word of the run.
  assign rd_word = (wr_en && (load_addr == idx_d)) ? load_data : mem_q[idx_d];
  assign instr_d = valid_d ? rd_word : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      n_q        <= '0;
      loop_q     <= 1'b0;
      loop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      loop_q     <= loop_d;
      loop_cnt_q <= loop_cnt_d;
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) stall_d = '0;
    else if (valid_q && !instr_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign pc_idx      = idx_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign loop_cnt    = loop_cnt_q;

endmodule

// File: tb/tb_instr_stream_feeder.sv
// Directed bench for instr_stream_feeder: load, stream, stall, loop, abort, reset, drops.
module tb_instr_stream_feeder;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 17;
  localparam int ADDR_W = 5;

  logic              clk, rst;
  logic              load_en, start, loop_mode, abort, instr_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] instr_out;
  logic              instr_valid, busy, done;
  logic [ADDR_W-1:0] pc_idx;
  logic [7:0]        loop_cnt;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int vec_cnt  = 0;
  int miss_cnt = 0;
  logic [DATA_W-1:0] exp_mem [DEPTH];

  instr_stream_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .count(count), .loop_mode(loop_mode), .abort(abort),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_idx(pc_idx), .busy(busy), .done(done),
`ifdef FEEDER_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .loop_cnt(loop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = addr[ADDR_W-1:0];
    load_data = data;
    tick();
    load_en   = 1'b0;
  endtask

  // Non-loop run with ready held high; checks each word, count and done pulse.
  task automatic run_check(input string tag, input int cnt, input int exp_n);
    int got;
    got = 0;
    count       = cnt[ADDR_W:0];
    loop_mode   = 1'b0;
    instr_ready = 1'b1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40 && instr_valid; c++) begin
      chk({tag, "_idx"}, 32'(pc_idx), got);
      if (got < DEPTH) chk({tag, "_word"}, instr_out, exp_mem[got]);
      got++;
      tick();
    end
    chk({tag, "_nwords"}, got, exp_n);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy_end"}, 32'(busy), 0);
    tick();
    chk({tag, "_done_clr"}, 32'(done), 0);
  endtask

  initial begin
    rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; count = '0; loop_mode = 1'b0; abort = 1'b0; instr_ready = 1'b0;
    #3;
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_idx", 32'(pc_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_loopcnt", 32'(loop_cnt), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h3C00_0000 + i;
    exp_mem[0] = 32'h2008_0005;
    exp_mem[1] = 32'h2009_0003;
    exp_mem[2] = 32'h0109_5020;
    for (int i = 0; i < DEPTH; i++) load(i, exp_mem[i]);

    // Basic three-word program, ready always high
    count = 6'd3; loop_mode = 1'b0; instr_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_w0", instr_out, 32'h2008_0005);
    chk("t1_i0", 32'(pc_idx), 0);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_w1", instr_out, 32'h2009_0003);
    chk("t1_i1", 32'(pc_idx), 1);
    tick();
    chk("t1_w2", instr_out, 32'h0109_5020);
    chk("t1_i2", 32'(pc_idx), 2);
    tick();
    chk("t1_done", 32'(done), 1);
    chk("t1_valid_off", 32'(instr_valid), 0);
    chk("t1_instr_nop", instr_out, 0);
    chk("t1_busy_off", 32'(busy), 0);
    tick();
    chk("t1_done_once", 32'(done), 0);

    // Back-pressure on word 1 for four cycles
    count = 6'd3; start = 1'b1; instr_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t2_w1", instr_out, 32'h2009_0003);
    instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_hold_w", instr_out, 32'h2009_0003);
      chk("t2_hold_i", 32'(pc_idx), 1);
      chk("t2_hold_v", 32'(instr_valid), 1);
    end
`ifdef FEEDER_STALL_CNT_EN
    chk("t2_stall_cnt", 32'(stall_cnt), 4);
`endif
    instr_ready = 1'b1;
    tick();
    chk("t2_w2", instr_out, 32'h0109_5020);
    tick();
    chk("t2_done", 32'(done), 1);
    tick();

    // Loop mode over two words, then abort
    count = 6'd2; loop_mode = 1'b1; instr_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk("t3_seq_idx", 32'(pc_idx), k % 2);
      chk("t3_seq_word", instr_out, exp_mem[k % 2]);
      chk("t3_no_done", 32'(done), 0);
      tick();
    end
    chk("t3_loopcnt", 32'(loop_cnt), 3);
    chk("t3_idx_after", 32'(pc_idx), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    loop_mode = 1'b0;
    chk("t3_abort_valid", 32'(instr_valid), 0);
    chk("t3_abort_idx", 32'(pc_idx), 0);
    chk("t3_abort_instr", instr_out, 0);
    chk("t3_abort_busy", 32'(busy), 0);
    chk("t3_abort_nodone", 32'(done), 0);
    tick();
    chk("t3_abort_nodone2", 32'(done), 0);

    // Zero count and saturated count
    count = 6'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_zero_done", 32'(done), 1);
    chk("t4_zero_valid", 32'(instr_valid), 0);
    chk("t4_zero_busy", 32'(busy), 0);
    tick();
    chk("t4_zero_done_clr", 32'(done), 0);
    run_check("t4_sat", 31, 17);

    // Asynchronous reset in the middle of a run
    count = 6'd17; instr_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("t5_at5", 32'(pc_idx), 5);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(instr_valid), 0);
    chk("t5_rst_instr", instr_out, 0);
    chk("t5_rst_idx", 32'(pc_idx), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_done", 32'(done), 0);
    chk("t5_rst_loopcnt", 32'(loop_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    run_check("t5_rerun", 3, 3);

    // Out-of-range load and loads during RUN must leave the store untouched
    load(20, 32'hBAD0_0020);
    count = 6'd4; instr_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    load_en = 1'b1; load_addr = 5'd3; load_data = 32'hDEAD_BEEF;
    for (int c = 0; c < 10 && instr_valid; c++) tick();
    load_en = 1'b0;
    chk("t6_run_ended", 32'(done), 1);
    tick();
    run_check("t6_verify", 31, 17);

    // Load and start together: the run sees the freshly loaded word
    load_en = 1'b1; load_addr = 5'd0; load_data = 32'hCAFE_0001;
    count = 6'd1; start = 1'b1; instr_ready = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    exp_mem[0] = 32'hCAFE_0001;
    chk("t7_bypass_word", instr_out, 32'hCAFE_0001);
    chk("t7_bypass_valid", 32'(instr_valid), 1);
    tick();
    chk("t7_done", 32'(done), 1);
    tick();
    run_check("t7_stored", 2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
